shared_ivc_bank_client: RTL and testbench

SHARED_IVC_BANK_CLIENT -- requirements
Module: shared_ivc_bank_client

---
 rtl/shared_ivc_bank_client_pkg.sv | 16 +
 rtl/shared_ivc_counter.sv | 40 ++++
 rtl/shared_ivc_bank_client.sv | 160 ++++++++++++++++
 tb/tb_shared_ivc_bank_client.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/shared_ivc_bank_client_pkg.sv
// Shared constants for the shared-IVC bank client: per-VC state encodings
// and the MSB-first bit mapping used on all per-VC and per-port vectors.
package vcr_constants;

    typedef enum logic [1:0] {
        VC_FREE    = 2'd0,
        VC_BUSY    = 2'd1,
        VC_CLOSING = 2'd2
    } vc_state_e;

    // Vectors are MSB-first: element idx of an n-wide vector sits at bit n-1-idx.
    function automatic int msb_first_bit(input int idx, input int n);
        return n - 1 - idx;
    endfunction

endpackage

// File: rtl/shared_ivc_counter.sv
// Flit occupancy counter for one shared IVC, with registered empty/full flags.
module shared_ivc_counter #(
    parameter int  buffer_depth = 8,
    localparam int cnt_w        = $clog2(buffer_depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [cnt_w-1:0] count_next,
    output logic             empty,
    output logic             full
);

    logic [cnt_w-1:0] count;

    // NOTE: default assignment first so every path assigns count_next and no latch is inferred.
    always_comb begin
        count_next = count;
        if (inc && !dec) begin
            count_next = count + cnt_w'(1);
        end else if (dec && !inc) begin
            count_next = count - cnt_w'(1);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == cnt_w'(buffer_depth));
        end
    end

endmodule

// File: rtl/shared_ivc_bank_client.sv
// Per-port client of a shared IVC memory bank: allocation, occupancy, close/free.
// Optional sticky protocol-error flag is built only with SHARED_IVC_ERROR_EN defined.
module shared_ivc_bank_client
    import vcr_constants::*;
#(
    parameter int  num_vcs_per_bank = 2,
    parameter int  num_ports        = 5,
    parameter int  port_id          = 0,
    parameter int  buffer_depth     = 8,
    localparam int vc_w             = (num_vcs_per_bank > 1) ? $clog2(num_vcs_per_bank) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [num_ports-1:0]        memory_bank_grant_in,
    input  logic                        ready_for_allocation_in,
    input  logic [num_vcs_per_bank-1:0] alloc_req,
    output logic [num_vcs_per_bank-1:0] alloc_gnt,
    input  logic                        flit_wr_valid,
    input  logic [vc_w-1:0]             flit_wr_vc,
    input  logic                        flit_wr_tail,
    input  logic                        flit_rd_valid,
    input  logic [vc_w-1:0]             flit_rd_vc,
    output logic [num_vcs_per_bank-1:0] allocated_shared_ivc,
    output logic [num_vcs_per_bank-1:0] shared_ivc_empty,
    output logic                        error
);

    localparam int cnt_w = $clog2(buffer_depth + 1);
    localparam logic [num_ports-1:0] own_mask =
        num_ports'(1) << msb_first_bit(port_id, num_ports);

    logic                        owned;
    logic [num_vcs_per_bank-1:0] req_vc;
    logic [num_vcs_per_bank-1:0] wr_ok;
    logic [num_vcs_per_bank-1:0] rd_ok;
    logic [num_vcs_per_bank-1:0] empty;
    logic [num_vcs_per_bank-1:0] full;
    logic [num_vcs_per_bank-1:0] gnt_sel;
    logic [num_vcs_per_bank-1:0] gnt_q;
    logic [num_vcs_per_bank-1:0] alloc_q;
    logic                        found;
    logic [cnt_w-1:0]            count_next [num_vcs_per_bank];
    vc_state_e                   state      [num_vcs_per_bank];
    vc_state_e                   state_next [num_vcs_per_bank];

    assign owned = |(memory_bank_grant_in & own_mask) && ready_for_allocation_in;

    // Internal vectors are indexed by VC number; the port vectors are MSB-first.
    always_comb begin
        req_vc               = '0;
        alloc_gnt            = '0;
        allocated_shared_ivc = '0;
        shared_ivc_empty     = '0;
        for (int i = 0; i < num_vcs_per_bank; i++) begin
            req_vc[i] = alloc_req[msb_first_bit(i, num_vcs_per_bank)];
            alloc_gnt[msb_first_bit(i, num_vcs_per_bank)]            = gnt_q[i] && owned;
            allocated_shared_ivc[msb_first_bit(i, num_vcs_per_bank)] = alloc_q[i];
            shared_ivc_empty[msb_first_bit(i, num_vcs_per_bank)]     = empty[i];
        end
    end

    // A read of an empty VC is legal only when the same VC is written that cycle.
    always_comb begin
        wr_ok = '0;
        rd_ok = '0;
        for (int i = 0; i < num_vcs_per_bank; i++) begin
            wr_ok[i] = flit_wr_valid && (flit_wr_vc == vc_w'(i))
                       && (state[i] != VC_FREE) && !full[i];
            rd_ok[i] = flit_rd_valid && (flit_rd_vc == vc_w'(i))
                       && (!empty[i] || wr_ok[i]);
        end
    end

    always_comb begin
        gnt_sel = '0;
        found   = 1'b0;
        if (owned) begin
            for (int i = 0; i < num_vcs_per_bank; i++) begin
                if (!found && req_vc[i] && (state[i] == VC_FREE)) begin
                    gnt_sel[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < num_vcs_per_bank; g++) begin : g_vc
            shared_ivc_counter #(
                .buffer_depth(buffer_depth)
            ) u_counter (
                .clk       (clk),
                .reset     (reset),
                .inc       (wr_ok[g]),
                .dec       (rd_ok[g]),
                .count_next(count_next[g]),
                .empty     (empty[g]),
                .full      (full[g])
            );
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < num_vcs_per_bank; i++) begin
            state_next[i] = state[i];
            case (state[i])
                VC_FREE: begin
                    if (gnt_sel[i]) state_next[i] = VC_BUSY;
                end
                VC_BUSY: begin
                    if (wr_ok[i] && flit_wr_tail) begin
                        state_next[i] = (count_next[i] == '0) ? VC_FREE : VC_CLOSING;
                    end
                end
                VC_CLOSING: begin
                    if (count_next[i] == '0) state_next[i] = VC_FREE;
                end
                default: state_next[i] = VC_FREE;
            endcase
        end
    end

    // NOTE: the per-VC state is a small register array, not a RAM, so it is reset with everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q   <= '0;
            alloc_q <= '0;
            for (int i = 0; i < num_vcs_per_bank; i++) begin
                state[i] <= VC_FREE;
            end
        end else begin
            gnt_q <= gnt_sel;
            for (int i = 0; i < num_vcs_per_bank; i++) begin
                state[i]   <= state_next[i];
                alloc_q[i] <= (state_next[i] != VC_FREE);
            end
        end
    end

`ifdef SHARED_IVC_ERROR_EN
    logic violation;
    logic error_q;

    // Any dropped write (full, FREE or out-of-range VC) or dropped read is a violation.
    assign violation = (flit_wr_valid && !(|wr_ok)) || (flit_rd_valid && !(|rd_ok));

    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (violation) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_shared_ivc_bank_client.sv
// Self-checking bench for shared_ivc_bank_client: vector table plus hand sequences,
// expected outputs queued at drive time and popped after the clock edge.
module tb_shared_ivc_bank_client;

`ifdef SHARED_IVC_ERROR_EN
    localparam bit err_en = 1'b1;
`else
    localparam bit err_en = 1'b0;
`endif

    localparam logic [4:0] own = 5'b10000;
    localparam logic [4:0] oth = 5'b01000;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] memory_bank_grant_in;
    logic       ready_for_allocation_in;
    logic [1:0] alloc_req;
    logic [1:0] alloc_gnt;
    logic       flit_wr_valid;
    logic       flit_wr_vc;
    logic       flit_wr_tail;
    logic       flit_rd_valid;
    logic       flit_rd_vc;
    logic [1:0] allocated_shared_ivc;
    logic [1:0] shared_ivc_empty;
    logic       error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [4:0] grant;
        logic       ready;
        logic [1:0] req;
        logic       wv;
        logic       wvc;
        logic       wt;
        logic       rv;
        logic       rvc;
        logic [1:0] gnt;
        logic [1:0] alloc;
        logic [1:0] empty;
        logic       err;
    } vec_t;

    typedef struct {
        logic [1:0] gnt;
        logic [1:0] alloc;
        logic [1:0] empty;
        logic       err;
    } exp_t;

    exp_t exp_q [$];
    vec_t tbl [14];

    shared_ivc_bank_client #(
        .num_vcs_per_bank(2),
        .num_ports       (5),
        .port_id         (0),
        .buffer_depth    (8)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .memory_bank_grant_in   (memory_bank_grant_in),
        .ready_for_allocation_in(ready_for_allocation_in),
        .alloc_req              (alloc_req),
        .alloc_gnt              (alloc_gnt),
        .flit_wr_valid          (flit_wr_valid),
        .flit_wr_vc             (flit_wr_vc),
        .flit_wr_tail           (flit_wr_tail),
        .flit_rd_valid          (flit_rd_valid),
        .flit_rd_vc             (flit_rd_vc),
        .allocated_shared_ivc   (allocated_shared_ivc),
        .shared_ivc_empty       (shared_ivc_empty),
        .error                  (error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t vec(input logic rst, input logic [4:0] grant, input logic ready,
                                 input logic [1:0] req, input logic wv, input logic wvc,
                                 input logic wt, input logic rv, input logic rvc,
                                 input logic [1:0] gnt, input logic [1:0] alloc,
                                 input logic [1:0] empty, input logic err);
        vec_t v;
        v = '{rst, grant, ready, req, wv, wvc, wt, rv, rvc, gnt, alloc, empty, err};
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        reset                   = v.rst;
        memory_bank_grant_in    = v.grant;
        ready_for_allocation_in = v.ready;
        alloc_req               = v.req;
        flit_wr_valid           = v.wv;
        flit_wr_vc              = v.wvc;
        flit_wr_tail            = v.wt;
        flit_rd_valid           = v.rv;
        flit_rd_vc              = v.rvc;
        e.gnt   = v.gnt;
        e.alloc = v.alloc;
        e.empty = v.empty;
        e.err   = err_en ? v.err : 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, " queue"}, 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, " alloc_gnt"}, 8'(alloc_gnt), 8'(e.gnt));
            check({tag, " allocated"}, 8'(allocated_shared_ivc), 8'(e.alloc));
            check({tag, " empty"}, 8'(shared_ivc_empty), 8'(e.empty));
            check({tag, " error"}, 8'(error), 8'(e.err));
        end
    endtask

    task automatic do_reset(input string tag);
        step(vec(1, 5'b0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0), tag);
    endtask

    initial begin
        reset = 1'b1;
        memory_bank_grant_in = '0;
        ready_for_allocation_in = 1'b0;
        alloc_req = '0;
        flit_wr_valid = 1'b0;
        flit_wr_vc = 1'b0;
        flit_wr_tail = 1'b0;
        flit_rd_valid = 1'b0;
        flit_rd_vc = 1'b0;

        //           rst grant rdy req   wv wvc wt rv rvc gnt    alloc  empty  err
        tbl[0]  = vec(0, oth, 1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0);
        tbl[1]  = vec(0, own, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0);
        tbl[2]  = vec(0, own, 1, 2'b01, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b11, 0);
        tbl[3]  = vec(0, own, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b11, 0);
        tbl[4]  = vec(0, own, 1, 2'b11, 0, 0, 0, 0, 0, 2'b10, 2'b11, 2'b11, 0);
        tbl[5]  = vec(0, own, 1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 0);
        tbl[6]  = vec(0, own, 1, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0);
        tbl[7]  = vec(0, own, 1, 2'b00, 1, 0, 1, 0, 0, 2'b00, 2'b11, 2'b00, 0);
        tbl[8]  = vec(0, own, 1, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b11, 2'b00, 0);
        tbl[9]  = vec(0, own, 1, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 0);
        tbl[10] = vec(0, own, 1, 2'b00, 1, 1, 0, 1, 1, 2'b00, 2'b01, 2'b10, 0);
        tbl[11] = vec(0, own, 1, 2'b00, 0, 0, 0, 1, 1, 2'b00, 2'b01, 2'b11, 0);
        tbl[12] = vec(0, own, 1, 2'b00, 1, 1, 1, 0, 0, 2'b00, 2'b01, 2'b10, 0);
        tbl[13] = vec(0, own, 1, 2'b00, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b11, 0);

        do_reset("reset0");
        do_reset("reset1");
        for (int i = 0; i < 14; i++) begin
            step(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Both VCs requested: lowest index first, one per cycle.
        do_reset("two_req rst");
        step(vec(0, own, 1, 2'b11, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b11, 0), "two_req c1");
        step(vec(0, own, 1, 2'b11, 0, 0, 0, 0, 0, 2'b01, 2'b11, 2'b11, 0), "two_req c2");
        step(vec(0, own, 1, 2'b11, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b11, 0), "two_req c3");

        // Grant is gated immediately when ownership drops; the VC keeps working.
        do_reset("gate rst");
        step(vec(0, own, 1, 2'b01, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b11, 0), "gate grant");
        ready_for_allocation_in = 1'b0;
        #1;
        check("gate alloc_gnt", 8'(alloc_gnt), 8'h00);
        check("gate allocated", 8'(allocated_shared_ivc), 8'h01);
        step(vec(0, own, 0, 2'b01, 1, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0), "gate drain");

        // Fill VC0 to depth, ninth write dropped, then drain exactly eight.
        do_reset("full rst");
        step(vec(0, own, 1, 2'b10, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b11, 0), "full alloc");
        for (int k = 0; k < 9; k++) begin
            step(vec(0, own, 1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, logic'(k == 8)),
                 $sformatf("full wr%0d", k));
        end
        for (int k = 0; k < 8; k++) begin
            step(vec(0, own, 1, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b10,
                     (k == 7) ? 2'b11 : 2'b01, 1), $sformatf("full rd%0d", k));
        end

        // Tail write and draining read together free VC1 in one cycle.
        do_reset("tail rst");
        step(vec(0, own, 1, 2'b01, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b11, 0), "tail alloc");
        step(vec(0, own, 1, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0), "tail wr");
        step(vec(0, own, 1, 2'b00, 0, 0, 0, 1, 1, 2'b00, 2'b01, 2'b11, 0), "tail rd");
        step(vec(0, own, 1, 2'b00, 1, 1, 1, 1, 1, 2'b00, 2'b00, 2'b11, 0), "tail wr+rd");
        step(vec(0, own, 1, 2'b01, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b11, 0), "tail realloc");

        // Read of empty VC0 and write to FREE VC1 are both dropped.
        do_reset("drop rst");
        step(vec(0, own, 1, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b11, 1), "drop rd empty");
        step(vec(0, own, 1, 2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b11, 1), "drop wr free");

        // Reset mid-packet discards all occupancy.
        do_reset("midrst rst");
        step(vec(0, own, 1, 2'b10, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b11, 0), "midrst alloc");
        for (int k = 0; k < 3; k++) begin
            step(vec(0, own, 1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0),
                 $sformatf("midrst wr%0d", k));
        end
        step(vec(1, own, 1, 2'b11, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b11, 0), "midrst reset");
        step(vec(0, 5'b0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0), "midrst idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
